// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: FIFO controller for an external dual-port RAM with a
// registered port-B read (1-cycle read latency).
// Optional sticky overflow/underflow flags are built when UART_FIFO_ERR_FLAG_EN
// is defined; otherwise o_ovf/o_udf are tied to 0.
module uart_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AFULL_LVL  = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_afull,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_ovf,
   output logic                  o_udf,
   output logic [ADDR_WIDTH-1:0] o_ram_addr_a,
   output logic [DATA_WIDTH-1:0] o_ram_data_a,
   output logic                  o_ram_wr_a,
   output logic [ADDR_WIDTH-1:0] o_ram_addr_b,
   output logic                  o_ram_wr_b,
   input  logic [DATA_WIDTH-1:0] i_ram_data_b
);

   localparam logic [ADDR_WIDTH:0] AfullLvl = AFULL_LVL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] PtrZero  = '0;

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic                rd_valid_q, rd_valid_d;
   logic                push_acc, pop_acc;

   // Status flags, derived from registered pointers only
   always_comb begin
      o_empty = (wr_ptr_q == rd_ptr_q);
      o_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
      o_count = wr_ptr_q - rd_ptr_q;
      o_afull = (o_count >= AfullLvl);
   end

   // Accept decisions; clear and reset suppress both sides, so no RAM write either
   always_comb begin
      pop_acc  = i_pop && !o_empty && !i_clr && !i_rst;
      push_acc = i_push && (!o_full || pop_acc) && !i_clr && !i_rst;
   end

   // RAM port drive: write on accepted push, read address always follows rd_ptr
   always_comb begin
      o_ram_wr_a   = push_acc;
      o_ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
      o_ram_data_a = i_wr_data;
      o_ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];
      o_ram_wr_b   = 1'b0;
      o_rd_data    = i_ram_data_b;
      o_rd_valid   = rd_valid_q;
   end

   // Pointer and read-valid next state; pointers wrap by natural overflow
   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push_acc};
      rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop_acc};
      rd_valid_d = pop_acc;
      if (i_clr) begin
         wr_ptr_d   = PtrZero;
         rd_ptr_d   = PtrZero;
         rd_valid_d = 1'b0;
      end
   end

   // Pointer and read-valid state with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= PtrZero;
         rd_ptr_q   <= PtrZero;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef UART_FIFO_ERR_FLAG_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky error flags; cleared only by reset or flush
   always_comb begin
      ovf_d = ovf_q | (i_push & ~push_acc);
      udf_d = udf_q | (i_pop & o_empty);
      if (i_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   // Error flag state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign o_ovf = ovf_q;
   assign o_udf = udf_q;
`else
   assign o_ovf = 1'b0;
   assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: directed scenarios plus random
// traffic checked against a queue-based FIFO model and a behavioural RAM.
module tb_uart_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;
`ifdef UART_FIFO_ERR_FLAG_EN
   localparam bit FlagEn = 1'b1;
`else
   localparam bit FlagEn = 1'b0;
`endif

   logic          i_clk;
   logic          i_rst, i_clr, i_push, i_pop;
   logic [DW-1:0] i_wr_data;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_valid, o_full, o_empty, o_afull, o_ovf, o_udf;
   logic [AW:0]   o_count;
   logic [AW-1:0] o_ram_addr_a, o_ram_addr_b;
   logic [DW-1:0] o_ram_data_a;
   logic          o_ram_wr_a, o_ram_wr_b;
   logic [DW-1:0] i_ram_data_b;

   uart_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_LVL (AFULL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (i_clr),
      .i_push      (i_push),
      .i_wr_data   (i_wr_data),
      .i_pop       (i_pop),
      .o_rd_data   (o_rd_data),
      .o_rd_valid  (o_rd_valid),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_afull     (o_afull),
      .o_count     (o_count),
      .o_ovf       (o_ovf),
      .o_udf       (o_udf),
      .o_ram_addr_a(o_ram_addr_a),
      .o_ram_data_a(o_ram_data_a),
      .o_ram_wr_a  (o_ram_wr_a),
      .o_ram_addr_b(o_ram_addr_b),
      .o_ram_wr_b  (o_ram_wr_b),
      .i_ram_data_b(i_ram_data_b)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Behavioural dual-port RAM, read-before-write, registered port B
   logic [DW-1:0] mem [DEPTH];
   always @(posedge i_clk) begin
      if (o_ram_wr_a) mem[o_ram_addr_a] <= o_ram_data_a;
      i_ram_data_b <= mem[o_ram_addr_b];
   end

   // Reference model state
   logic [DW-1:0] mq[$];
   int            wr_n, rd_n;
   bit            m_ovf, m_udf, m_valid;
   logic [DW-1:0] m_data;
   int            n_assert, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check RAM-side combinational outputs, clock,
   // advance model, check registered outputs.
   task automatic step(input bit push, input logic [DW-1:0] d, input bit pop,
                       input bit clr, input bit rst);
      int  sz;
      bit  pop_ok, push_ok;
      i_push = push; i_wr_data = d; i_pop = pop; i_clr = clr; i_rst = rst;
      #1;
      sz      = mq.size();
      pop_ok  = !rst && !clr && pop && (sz > 0);
      push_ok = !rst && !clr && push && ((sz < DEPTH) || pop_ok);
      chk("ram_wr_a", {31'd0, o_ram_wr_a}, {31'd0, push_ok});
      chk("ram_wr_b", {31'd0, o_ram_wr_b}, 32'd0);
      chk("ram_addr_b", {29'd0, o_ram_addr_b}, rd_n % DEPTH);
      if (push_ok) begin
         chk("ram_addr_a", {29'd0, o_ram_addr_a}, wr_n % DEPTH);
         chk("ram_data_a", {24'd0, o_ram_data_a}, {24'd0, d});
      end
      @(posedge i_clk);
      if (rst || clr) begin
         mq.delete();
         wr_n = 0; rd_n = 0;
         m_valid = 0; m_ovf = 0; m_udf = 0;
      end else begin
         if (push && !push_ok) m_ovf = 1;
         if (pop && sz == 0) m_udf = 1;
         m_valid = pop_ok;
         if (pop_ok) begin
            m_data = mq.pop_front();
            rd_n++;
         end
         if (push_ok) begin
            mq.push_back(d);
            wr_n++;
         end
      end
      @(negedge i_clk);
      sz = mq.size();
      chk("count", {28'd0, o_count}, sz);
      chk("empty", {31'd0, o_empty}, {31'd0, sz == 0});
      chk("full", {31'd0, o_full}, {31'd0, sz == DEPTH});
      chk("afull", {31'd0, o_afull}, {31'd0, sz >= AFULL});
      chk("rd_valid", {31'd0, o_rd_valid}, {31'd0, m_valid});
      if (m_valid) chk("rd_data", {24'd0, o_rd_data}, {24'd0, m_data});
      chk("ovf", {31'd0, o_ovf}, {31'd0, FlagEn & m_ovf});
      chk("udf", {31'd0, o_udf}, {31'd0, FlagEn & m_udf});
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      wr_n = 0; rd_n = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_data = '0;
      i_rst = 1'b1; i_clr = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_wr_data = '0;
      @(negedge i_clk);

      // Reset state
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 0);

      // Fill with 0x11..0x88
      for (int i = 1; i <= DEPTH; i++) step(1, 8'(i * 8'h11), 0, 0, 0);
      // Push into full FIFO is rejected
      step(1, 8'h99, 0, 0, 0);
      // Push and pop when full: both accepted
      step(1, 8'hAA, 1, 0, 0);
      // Drain: 0x22..0x88 then 0xAA
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
      // Idle cycle so rd_valid deasserts
      step(0, 8'h00, 0, 0, 0);
      // Push and pop when empty: only the push is taken
      step(1, 8'h55, 1, 0, 0);
      // Push/pop streaming across pointer wrap
      for (int i = 0; i < 20; i++) step(1, 8'($urandom_range(0, 255)), 1, 0, 0);

      // Random traffic with occasional flush
      for (int i = 0; i < 300; i++)
         step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), 1'b0);

      // Three stored, pop, then flush with push held
      step(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(1, 8'hEE, 0, 1, 0);
      step(0, 8'h00, 0, 0, 0);

      // Same sequence using reset
      for (int i = 0; i < 3; i++) step(1, 8'(8'hD0 + i), 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(1, 8'hEF, 1, 1, 1);
      step(0, 8'h00, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning FIFO word width, equal to the RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning RAM address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_LVL, default 6, meaning the count at or above which o_afull asserts; legal range 1..2**ADDR_WIDTH.
REQ-004 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_clr  in  1  synchronous flush.
- i_push  in  1  write request.
- i_wr_data  in  DATA_WIDTH  write word.
- i_pop  in  1  read request.
- o_rd_data  out  DATA_WIDTH  read word.
- o_rd_valid  out  1  o_rd_data valid this cycle.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_afull  out  1  count >= AFULL_LVL.
- o_count  out  ADDR_WIDTH+1  stored words.
- o_ovf  out  1  sticky overflow.
- o_udf  out  1  sticky underflow.
- o_ram_addr_a  out  ADDR_WIDTH  RAM port A address (write side).
- o_ram_data_a  out  DATA_WIDTH  RAM port A write data.
- o_ram_wr_a  out  1  RAM port A write enable.
- o_ram_addr_b  out  ADDR_WIDTH  RAM port B address (read side).
- o_ram_wr_b  out  1  RAM port B write enable; constant 0.
- i_ram_data_b  in  DATA_WIDTH  RAM port B registered read data.

Function
REQ-005 SHALL hold wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits are the RAM address and the MSB is a wrap bit.
REQ-006 SHALL derive o_empty = (wr_ptr == rd_ptr), o_full = (address bits equal AND wrap bits differ), and o_count = wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1); all are registered-state derived, with no combinational path from i_push/i_pop.
REQ-007 SHALL accept a push when i_push && (!o_full || accepted pop same cycle).
- On accept: o_ram_wr_a=1, o_ram_addr_a=wr_ptr[ADDR_WIDTH-1:0], o_ram_data_a=i_wr_data, and wr_ptr increments at the clock edge.
- o_ram_wr_a SHALL be combinational from the accept condition.
REQ-008 SHALL accept a pop when i_pop && !o_empty.
- o_ram_addr_b=rd_ptr[ADDR_WIDTH-1:0] at all times.
- rd_ptr increments at the clock edge.
- o_rd_valid asserts exactly one cycle later.
- o_rd_data = i_ram_data_b, so read latency is 1 cycle.
REQ-009 Simultaneous push and pop when full SHALL accept both; the RAM returns the old word on port B, count stays 2**ADDR_WIDTH.
REQ-010 Simultaneous push and pop when empty SHALL accept the push only; the pop is rejected, o_rd_valid stays 0 next cycle, and count becomes 1.
REQ-011 A rejected push SHALL leave the RAM and wr_ptr unchanged; a rejected pop SHALL leave rd_ptr unchanged.
REQ-012 Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 SHALL be natural modulo overflow.
REQ-013 i_clr SHALL set both pointers to 0 and clear o_rd_valid, o_ovf and o_udf at the next edge; clr overrides push and pop in the same cycle, and RAM contents are not erased.
REQ-014 o_afull SHALL equal (o_count >= AFULL_LVL).

Reset
REQ-015 i_rst SHALL, at the next rising edge, set wr_ptr=0, rd_ptr=0, o_rd_valid=0, o_ovf=0 and o_udf=0, giving o_empty=1, o_full=0, o_afull=0 and o_count=0; it has priority over i_clr, i_push and i_pop.
REQ-016 Reset asserted mid-operation SHALL discard all stored words and any pending o_rd_valid.

Configuration
REQ-017 Macro UART_FIFO_ERR_FLAG_EN:
- Defined: o_ovf sets on i_push && !accepted; o_udf sets on i_pop && o_empty. Both hold until i_rst or i_clr.
- Undefined: o_ovf and o_udf are constant 0, the flag registers are not built, and the ports remain.

Verification
REQ-018 Reset then 8 pushes 0x11..0x88 -> o_full=1, o_count=8, o_afull=1 from the 6th push onward, RAM addresses written 0..7.
REQ-019 Full FIFO, push 0x99 alone -> o_count=8, word rejected; with macro o_ovf=1, without macro o_ovf=0.
REQ-020 8 pops after REQ-018 -> o_rd_valid one cycle after each pop with data 0x11..0x88 in order, o_empty=1 after the last pop.
REQ-021 Full FIFO, push 0xAA with pop same cycle -> popped 0x11 is valid next cycle, o_count=8, 0xAA is later read at the tail.
REQ-022 Empty FIFO, push 0x55 with pop same cycle -> no o_rd_valid, o_count=1, o_udf=1 with macro; 20 push/pop cycles exercise wrap with data intact.
REQ-023 3 words stored, pop then i_clr next cycle with i_push=1 -> o_rd_valid=0, o_count=0, o_empty=1; same sequence with i_rst -> identical result.
